// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - frame-periodic ADC channel scanner with per-channel holding registers
// Define ADC_SEQ_FILTER_EN to build a first-order IIR smoother into every holding slot.
module adc_scan_sequencer #(
    parameter int NUM_CH         = 4,
    parameter int CH_BASE        = 1,
    parameter int FRAME_CYCLES   = 50000,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    ch_mask,
    output logic                 cmd_valid,
    output logic [4:0]           cmd_channel,
    output logic                 cmd_sop,
    output logic                 cmd_eop,
    input  logic                 cmd_ready,
    input  logic                 rsp_valid,
    input  logic [4:0]           rsp_channel,
    input  logic [11:0]          rsp_data,
    output logic [NUM_CH*12-1:0] sample_data,
    output logic [NUM_CH-1:0]    sample_strobe,
    output logic                 frame_done,
    output logic                 err_timeout,
    output logic                 err_mismatch,
    input  logic                 err_clear
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        ADVANCE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [FW-1:0]     frame_cnt;
    logic              tick;
    logic [NUM_CH-1:0] mask_q;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     first_idx;
    logic [IW-1:0]     next_idx;
    logic              next_found;
    logic [TW-1:0]     tmo_cnt;
    logic [4:0]        exp_ch;
    logic              rsp_hit;
    logic              timeout_hit;
    logic              mismatch_hit;
    logic [11:0]       slot [NUM_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (!enable || frame_cnt == FW'(FRAME_CYCLES - 1)) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign tick = enable && (frame_cnt == FW'(FRAME_CYCLES - 1));

    // Lowest set bit of the live mask for frame start; next set bit above idx of the latched mask.
    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_idx = IW'(i);
            end
            if (mask_q[i] && (IW'(i) > idx)) begin
                next_idx   = IW'(i);
                next_found = 1'b1;
            end
        end
    end

    assign exp_ch       = 5'(CH_BASE) + 5'(idx);
    assign rsp_hit      = (state == WAIT_RSP) && rsp_valid && (rsp_channel == exp_ch);
    assign timeout_hit  = (state == WAIT_RSP) && !rsp_hit && (tmo_cnt == TW'(TIMEOUT_CYCLES));
    assign mismatch_hit = rsp_valid && !rsp_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Enable is only consulted between channels so an accepted command always sees its response.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (tick && (|ch_mask)) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rsp_hit || timeout_hit) begin
                    state_nxt = ADVANCE;
                end
            end
            ADVANCE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (next_found) begin
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_valid   = (state == ISSUE);
        cmd_channel = (state == ISSUE) ? exp_ch : 5'd0;
        cmd_sop     = (state == ISSUE);
        cmd_eop     = (state == ISSUE);
        frame_done  = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q  <= '0;
            idx     <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == IDLE && tick && (|ch_mask)) begin
                mask_q <= ch_mask;
                idx    <= first_idx;
            end else if (state == ADVANCE && next_found) begin
                idx <= next_idx;
            end
            if (state == WAIT_RSP) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_timeout  <= 1'b0;
            err_mismatch <= 1'b0;
        end else begin
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clear) begin
                err_timeout <= 1'b0;
            end
            if (mismatch_hit) begin
                err_mismatch <= 1'b1;
            end else if (err_clear) begin
                err_mismatch <= 1'b0;
            end
        end
    end

`ifdef ADC_SEQ_FILTER_EN
    logic primed [NUM_CH];

    function automatic logic [11:0] iir_step(input logic [11:0] cur, input logic [11:0] smp);
        logic signed [13:0] diff;
        logic signed [13:0] sum;
        diff = $signed({2'b00, smp}) - $signed({2'b00, cur});
        sum  = $signed({2'b00, cur}) + (diff >>> 2);
        return sum[11:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_strobe <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                slot[i]   <= '0;
                primed[i] <= 1'b0;
            end
        end else begin
            sample_strobe <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (rsp_hit && idx == IW'(i)) begin
                    sample_strobe[i] <= 1'b1;
                    primed[i]        <= 1'b1;
                    slot[i]          <= primed[i] ? iir_step(slot[i], rsp_data) : rsp_data;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_strobe <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                slot[i] <= '0;
            end
        end else begin
            sample_strobe <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (rsp_hit && idx == IW'(i)) begin
                    sample_strobe[i] <= 1'b1;
                    slot[i]          <= rsp_data;
                end
            end
        end
    end
`endif

    always_comb begin
        sample_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sample_data[12*i +: 12] = slot[i];
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - scoreboard bench for adc_scan_sequencer with a reactive ADC model
module tb_adc_scan_sequencer;

    localparam int NUM_CH = 4;
    localparam int CH_BASE = 1;
    localparam int FC = 64;
    localparam int TMO = 255;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic [NUM_CH-1:0]    ch_mask;
    logic                 cmd_valid;
    logic [4:0]           cmd_channel;
    logic                 cmd_sop;
    logic                 cmd_eop;
    logic                 cmd_ready;
    logic                 rsp_valid;
    logic [4:0]           rsp_channel;
    logic [11:0]          rsp_data;
    logic [NUM_CH*12-1:0] sample_data;
    logic [NUM_CH-1:0]    sample_strobe;
    logic                 frame_done;
    logic                 err_timeout;
    logic                 err_mismatch;
    logic                 err_clear;

    int checks = 0;
    int errors = 0;
    int frame_cnt = 0;

    logic [4:0]  cmd_log [$];
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];

    int          drop_ch = -1;
    bit          inject_mm = 1'b0;
    bit          ovr_en = 1'b0;
    logic [11:0] ovr_data = 12'h000;
    logic [11:0] slot_m [NUM_CH];
    bit          primed_m [NUM_CH];

    adc_scan_sequencer #(
        .NUM_CH(NUM_CH),
        .CH_BASE(CH_BASE),
        .FRAME_CYCLES(FC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .ch_mask(ch_mask),
        .cmd_valid(cmd_valid),
        .cmd_channel(cmd_channel),
        .cmd_sop(cmd_sop),
        .cmd_eop(cmd_eop),
        .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid),
        .rsp_channel(rsp_channel),
        .rsp_data(rsp_data),
        .sample_data(sample_data),
        .sample_strobe(sample_strobe),
        .frame_done(frame_done),
        .err_timeout(err_timeout),
        .err_mismatch(err_mismatch),
        .err_clear(err_clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ADC model: answers each accepted command two cycles later and predicts the slot value.
    initial begin
        logic [4:0]  ch;
        logic [11:0] d;
        int          li;
        rsp_valid   = 1'b0;
        rsp_channel = 5'd0;
        rsp_data    = 12'h000;
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    primed_m[i] = 1'b0;
                    slot_m[i]   = 12'h000;
                end
            end else if (cmd_valid && cmd_ready) begin
                ch = cmd_channel;
                cmd_log.push_back(ch);
                li = int'(ch) - CH_BASE;
                @(posedge clk);
                if (int'(ch) != drop_ch) begin
                    @(posedge clk);
                    #1;
                    if (inject_mm) begin
                        rsp_valid   = 1'b1;
                        rsp_channel = 5'd7;
                        rsp_data    = 12'h555;
                        @(posedge clk);
                        #1;
                    end
                    d = ovr_en ? ovr_data : (12'h100 + 12'(ch));
                    rsp_valid   = 1'b1;
                    rsp_channel = ch;
                    rsp_data    = d;
`ifdef ADC_SEQ_FILTER_EN
                    if (primed_m[li]) begin
                        d = 12'(int'(slot_m[li]) + ((int'(d) - int'(slot_m[li])) >>> 2));
                    end
`endif
                    primed_m[li] = 1'b1;
                    slot_m[li]   = d;
                    exp_q.push_back({4'(li), d});
                    @(posedge clk);
                    #1;
                    rsp_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) frame_cnt++;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sample_strobe[i] === 1'b1) obs_q.push_back({4'(i), sample_data[12*i +: 12]});
            end
        end
    end

    task automatic wait_frames(input int target, input int limit, output bit ok);
        int k;
        k = 0;
        while (frame_cnt < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        ok = (frame_cnt >= target);
    endtask

    task automatic stop_scan;
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_reset;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b required 0", cmd_valid); end
        checks++; if (cmd_channel !== 5'd0) begin errors++; $display("FAIL reset_cmd_channel: got %0d required 0", cmd_channel); end
        checks++; if ({cmd_sop, cmd_eop} !== 2'b00) begin errors++; $display("FAIL reset_sop_eop: got %b required 00", {cmd_sop, cmd_eop}); end
        checks++; if (sample_data !== '0) begin errors++; $display("FAIL reset_sample_data: got %h required 0", sample_data); end
        checks++; if (sample_strobe !== '0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b/%b required 0/0", sample_strobe, frame_done); end
        checks++; if ({err_timeout, err_mismatch} !== 2'b00) begin errors++; $display("FAIL reset_errors: got %b required 00", {err_timeout, err_mismatch}); end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL idle_disabled: cmd_valid got %b required 0", cmd_valid); end
    endtask

    task automatic test_basic_scan;
        logic [4:0]  exp_ch [6] = '{5'd1, 5'd2, 5'd4, 5'd1, 5'd2, 5'd4};
        logic [15:0] e;
        logic [15:0] o;
        int          f0;
        bit          ok;
        cmd_log.delete(); exp_q.delete(); obs_q.delete();
        f0 = frame_cnt;
        @(posedge clk);
        #1 ch_mask = 4'b1011; enable = 1'b1;
        wait_frames(f0 + 2, 4 * FC, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_frames: got %0d frame_done required 2", frame_cnt - f0); end
        stop_scan();
        checks++; if (frame_cnt - f0 != 2) begin errors++; $display("FAIL basic_frame_count: got %0d required 2", frame_cnt - f0); end
        checks++; if (cmd_log.size() != 6) begin errors++; $display("FAIL basic_cmd_count: got %0d required 6", cmd_log.size()); end
        for (int i = 0; i < 6 && i < cmd_log.size(); i++) begin
            checks++; if (cmd_log[i] !== exp_ch[i]) begin errors++; $display("FAIL basic_cmd_order[%0d]: got %0d required %0d", i, cmd_log[i], exp_ch[i]); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL basic_strobe: got none required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL basic_strobe: got %h required %h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL basic_extra_strobe: got %0d extra required 0", obs_q.size()); end
        checks++; if (sample_data[11:0] !== 12'h101) begin errors++; $display("FAIL basic_slot0: got %h required 101", sample_data[11:0]); end
        checks++; if (sample_data[23:12] !== 12'h102) begin errors++; $display("FAIL basic_slot1: got %h required 102", sample_data[23:12]); end
        checks++; if (sample_data[35:24] !== 12'h000) begin errors++; $display("FAIL basic_slot2: got %h required 000", sample_data[35:24]); end
        checks++; if (sample_data[47:36] !== 12'h104) begin errors++; $display("FAIL basic_slot3: got %h required 104", sample_data[47:36]); end
    endtask

    task automatic test_backpressure;
        logic [15:0] e;
        logic [15:0] o;
        int          f0;
        int          k;
        int          bad;
        bit          ok;
        cmd_log.delete(); exp_q.delete(); obs_q.delete();
        f0 = frame_cnt;
        @(posedge clk);
        #1 cmd_ready = 1'b0; enable = 1'b1;
        k = 0;
        while (cmd_valid !== 1'b1 && k < 2 * FC) begin @(negedge clk); k++; end
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_rise: got %b required 1", cmd_valid); end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_valid !== 1'b1 || cmd_channel !== 5'd1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles required 0", bad); end
        checks++; if (cmd_log.size() != 0) begin errors++; $display("FAIL bp_no_accept: got %0d accepted required 0", cmd_log.size()); end
        @(posedge clk);
        #1 cmd_ready = 1'b1;
        wait_frames(f0 + 1, 2 * FC, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_frame: got %0d frame_done required 1", frame_cnt - f0); end
        stop_scan();
        checks++; if (cmd_log.size() != 3) begin errors++; $display("FAIL bp_cmd_count: got %0d required 3", cmd_log.size()); end
        checks++; if (cmd_log.size() == 0 || cmd_log[0] !== 5'd1) begin errors++; $display("FAIL bp_first_cmd: got %0d entries required first channel 1", cmd_log.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL bp_strobe: got none required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL bp_strobe: got %h required %h", o, e); end end
        end
    endtask

    task automatic test_timeout;
        logic [15:0] e;
        logic [15:0] o;
        int          f0;
        int          k;
        bit          ok;
        cmd_log.delete(); exp_q.delete(); obs_q.delete();
        f0 = frame_cnt;
        drop_ch = 2; ovr_en = 1'b1; ovr_data = 12'h3C0;
        @(posedge clk);
        #1 ch_mask = 4'b1011; enable = 1'b1;
        k = 0;
        while (cmd_log.size() < 2 && k < 2 * FC) begin @(negedge clk); k++; end
        checks++; if (cmd_log.size() < 2) begin errors++; $display("FAIL to_second_cmd: got %0d commands required 2", cmd_log.size()); end
        repeat (200) @(negedge clk);
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %b required 0", err_timeout); end
        wait_frames(f0 + 1, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_frame: got %0d frame_done required 1", frame_cnt - f0); end
        stop_scan();
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b required 1", err_timeout); end
        checks++; if (sample_data[23:12] !== 12'h102) begin errors++; $display("FAIL to_slot1: got %h required 102", sample_data[23:12]); end
        checks++; if (cmd_log.size() != 3 || cmd_log[2] !== 5'd4) begin errors++; $display("FAIL to_ch4_issued: got %0d commands required 3 ending with 4", cmd_log.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL to_strobe: got none required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL to_strobe: got %h required %h", o, e); end end
        end
        @(posedge clk);
        #1 err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
        @(negedge clk);
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b required 0", err_timeout); end
        drop_ch = -1; ovr_en = 1'b0;
    endtask

    task automatic test_mismatch;
        logic [15:0] e;
        logic [15:0] o;
        int          f0;
        bit          ok;
        pulse_reset();
        cmd_log.delete(); exp_q.delete(); obs_q.delete();
        f0 = frame_cnt;
        inject_mm = 1'b1; ovr_en = 1'b1; ovr_data = 12'hABC;
        @(posedge clk);
        #1 ch_mask = 4'b0001; enable = 1'b1;
        wait_frames(f0 + 1, 2 * FC, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mm_frame: got %0d frame_done required 1", frame_cnt - f0); end
        stop_scan();
        inject_mm = 1'b0; ovr_en = 1'b0;
        checks++; if (err_mismatch !== 1'b1) begin errors++; $display("FAIL mm_flag: got %b required 1", err_mismatch); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL mm_no_timeout: got %b required 0", err_timeout); end
        checks++; if (sample_data[11:0] !== 12'hABC) begin errors++; $display("FAIL mm_slot0: got %h required abc", sample_data[11:0]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL mm_strobe: got none required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL mm_strobe: got %h required %h", o, e); end end
        end
        @(posedge clk);
        #1 err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
        @(negedge clk);
        checks++; if (err_mismatch !== 1'b0) begin errors++; $display("FAIL mm_clear: got %b required 0", err_mismatch); end
    endtask

    task automatic test_midframe;
        logic [15:0] e;
        logic [15:0] o;
        int          f0;
        int          k;
        cmd_log.delete(); exp_q.delete(); obs_q.delete();
        f0 = frame_cnt;
        ovr_en = 1'b1; ovr_data = 12'h2A0;
        @(posedge clk);
        #1 ch_mask = 4'b1011; enable = 1'b1;
        k = 0;
        while (cmd_log.size() < 1 && k < 2 * FC) begin @(negedge clk); k++; end
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (2 * FC) @(negedge clk);
        ovr_en = 1'b0;
        checks++; if (frame_cnt != f0) begin errors++; $display("FAIL mid_no_frame_done: got %0d required 0", frame_cnt - f0); end
        checks++; if (cmd_log.size() != 1) begin errors++; $display("FAIL mid_cmd_count: got %0d required 1", cmd_log.size()); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_idle: cmd_valid got %b required 0", cmd_valid); end
        checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL mid_rsp_sent: got %0d responses required 1", exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL mid_strobe: got none required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL mid_strobe: got %h required %h", o, e); end end
        end
    endtask

    task automatic test_reset_mid_issue;
        int k;
        @(posedge clk);
        #1 cmd_ready = 1'b0; enable = 1'b1;
        k = 0;
        while (cmd_valid !== 1'b1 && k < 2 * FC) begin @(negedge clk); k++; end
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL rst_issue_reach: got %b required 1", cmd_valid); end
        #1 reset = 1'b1;
        #1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_drop: got %b required 0", cmd_valid); end
        checks++; if (sample_data !== '0) begin errors++; $display("FAIL rst_issue_data: got %h required 0", sample_data); end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0; enable = 1'b0; cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_after: got %b required 0", cmd_valid); end
    endtask

`ifdef ADC_SEQ_FILTER_EN
    task automatic test_filter;
        logic [15:0] e;
        logic [15:0] o;
        int          f0;
        bit          ok;
        pulse_reset();
        cmd_log.delete(); exp_q.delete(); obs_q.delete();
        f0 = frame_cnt;
        ovr_en = 1'b1; ovr_data = 12'h000;
        @(posedge clk);
        #1 ch_mask = 4'b0001; enable = 1'b1;
        wait_frames(f0 + 1, 2 * FC, ok);
        checks++; if (sample_data[11:0] !== 12'h000) begin errors++; $display("FAIL filt_first: got %h required 000", sample_data[11:0]); end
        ovr_data = 12'h400;
        wait_frames(f0 + 2, 2 * FC, ok);
        checks++; if (!ok) begin errors++; $display("FAIL filt_frames: got %0d required 2", frame_cnt - f0); end
        stop_scan();
        ovr_en = 1'b0;
        checks++; if (sample_data[11:0] !== 12'h100) begin errors++; $display("FAIL filt_second: got %h required 100", sample_data[11:0]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL filt_strobe: got none required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL filt_strobe: got %h required %h", o, e); end end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        ch_mask   = '0;
        cmd_ready = 1'b1;
        err_clear = 1'b0;
        test_reset();
        test_basic_scan();
        test_backpressure();
        test_timeout();
        test_mismatch();
        test_midframe();
        test_reset_mid_issue();
`ifdef ADC_SEQ_FILTER_EN
        test_filter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Drives the modular ADC command/response Avalon-ST ports exported by the SoC.
- Scans a programmable set of analog channels (joystick/paddle inputs) once per frame period.
- Keeps the latest 12-bit result per channel in holding registers for game logic.
- Detects lost or mismatched responses so the scan never stalls.

Parameters:
- NUM_CH, 4, number of logical channels scanned (1..8)
- CH_BASE, 1, ADC channel number of logical channel 0; logical i maps to CH_BASE+i
- FRAME_CYCLES, 50000, clock cycles between frame starts (1 kHz at 50 MHz); must be greater than 0
- TIMEOUT_CYCLES, 255, cycles to wait for a response before skipping a channel

Ports:
- clk  in  1  system clock; also the SoC clock domain
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; scanning runs while high
- ch_mask  in  NUM_CH  bit i set = scan logical channel i
- cmd_valid  out  1  to modular_adc_0_command_valid
- cmd_channel  out  5  to modular_adc_0_command_channel
- cmd_sop  out  1  to command_startofpacket; tied high whenever cmd_valid is high
- cmd_eop  out  1  to command_endofpacket; tied high whenever cmd_valid is high
- cmd_ready  in  1  from modular_adc_0_command_ready
- rsp_valid  in  1  from modular_adc_0_response_valid
- rsp_channel  in  5  from response_channel
- rsp_data  in  12  from response_data
- sample_data  out  NUM_CH*12  holding registers; logical i occupies bits [12i+11:12i]
- sample_strobe  out  NUM_CH  one-cycle pulse when channel i is updated
- frame_done  out  1  one-cycle pulse at the end of each scan
- err_timeout  out  1  sticky; set on any timeout
- err_mismatch  out  1  sticky; set on an unexpected rsp_channel
- err_clear  in  1  synchronous clear of both sticky errors

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; frame counter 0.
- Frame counter:
  - Free-runs 0..FRAME_CYCLES-1 while enable is high; held at 0 while enable is low.
  - Wrap produces the internal tick.
- FSM states: IDLE, ISSUE, WAIT_RSP, ADVANCE, DONE.
  - IDLE: on tick with ch_mask != 0, load index with the lowest set bit, go to ISSUE. If ch_mask == 0, stay in IDLE and emit no frame_done.
  - ISSUE: cmd_valid=1, cmd_channel=CH_BASE+index. Hold valid and channel stable until cmd_ready; the transfer completes on the cycle cmd_valid&&cmd_ready. Then go to WAIT_RSP and clear the timeout counter.
  - WAIT_RSP:
    - On rsp_valid with rsp_channel==CH_BASE+index: write rsp_data into slot index, pulse sample_strobe[index] the next cycle, go to ADVANCE.
    - On rsp_valid with any other channel: discard the response, set err_mismatch, keep waiting.
    - Counter reaches TIMEOUT_CYCLES: set err_timeout, leave the slot unchanged, go to ADVANCE.
  - ADVANCE: find the next set bit above index in ch_mask, sampled at frame start. If one exists go to ISSUE; otherwise go to DONE.
  - DONE: pulse frame_done for 1 cycle, return to IDLE.
- ch_mask is latched at frame start; changes mid-frame take effect at the next frame.
- Dropping enable mid-frame: the current command/response completes, then the FSM goes to IDLE without frame_done. cmd_valid is never withdrawn before ready.
- A tick arriving while not in IDLE is dropped. There is no frame queueing, and the overrun is not counted as an error.
- Latency: strobe pulses 1 cycle after the accepted rsp_valid. One command is outstanding at most.
- err_clear and a simultaneous error set: set wins.
- rsp_valid arriving in IDLE/ISSUE/ADVANCE/DONE is ignored and sets err_mismatch.

Optional Feature:
- Macro ADC_SEQ_FILTER_EN.
- When defined, each slot is a first-order IIR: slot <= slot + ((rsp_data - slot) >>> 2).
  - Arithmetic uses 14-bit signed intermediate; the result is truncated to 12 bits.
  - The first valid sample after reset loads directly; a per-slot primed flag tracks this.
  - Strobe timing is unchanged.
- When undefined, the slot takes rsp_data raw; no filter logic and no primed flags are synthesized.

Test Plan:
- Basic scan: NUM_CH=4, ch_mask=4'b1011, ADC model ready immediately, rsp_data=0x100+channel 2 cycles later. Required: commands on channels 1,2,4 in order; slots 0,1,3 = 0x101,0x102,0x104; slot 2 stays 0; one frame_done per tick.
- Backpressure: hold cmd_ready low 10 cycles. Required: cmd_valid high and cmd_channel=1 stable all 10 cycles; exactly one command is accepted.
- Timeout: no response for channel 2. Required: err_timeout set after 255 cycles; slot 1 unchanged; channel 4 is still issued; frame_done fires.
- Mismatch: response channel 7 while waiting on channel 1, then a correct response 0xABC. Required: err_mismatch=1; slot 0=0xABC; err_clear clears the flag.
- Mid-frame control: deassert enable during WAIT_RSP. Required: the response is stored, the FSM returns to IDLE with no frame_done, and no further commands issue. Asserting reset mid-ISSUE forces cmd_valid=0 immediately.
- ADC_SEQ_FILTER_EN: samples 0x000 then 0x400. Required: slot = 0x000 then 0x100.
